// File: rtl/lc3_ctrl_fsm_pkg.sv
// Shared state encoding, opcode constants, mux encodings and control word for the LC-3 sequencer.
// Pure definitions: no latency and no handshake of its own.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_PAUSE_IR1,
        S_PAUSE_IR2,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR,
        S_BR_TAKE,
        S_JMP,
        S_JSR,
        S_JSR_OFF,
        S_JSRR,
        S_LDR1,
        S_LDR2,
        S_LDR3,
        S_STR1,
        S_STR2,
        S_STR3,
        S_PAUSE1,
        S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    // Idle word: every load/gate low, SRAM strobes (active-low) released.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/lc3_ctrl_fsm_mem_wait_ctr.sv
// Loadable down-counter with zero flag that times SRAM strobes; load/decrement take effect next edge.
// No backpressure: decrement saturates at zero, load has priority.
module mem_wait_ctr #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 instruction sequencer: one state per control step, outputs decoded from state (plus wait-counter/IR bits).
// Latency per instruction fixed by opcode and MEM_WAIT; stalls only in PAUSE states on the Continue switch.
module lc3_ctrl_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter bit PAUSE_EN = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t state, state_nxt;
    ctrl_t  ctl;
    logic   ctr_load;
    logic   ctr_dec;
    logic   ctr_zero;

    mem_wait_ctr #(.WIDTH(4)) u_wait_ctr (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (ctr_load),
        .load_val (WAIT_LOAD),
        .dec      (ctr_dec),
        .zero     (ctr_zero)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_HALTED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctl       = ctrl_idle();
        ctr_load  = 1'b0;
        ctr_dec   = 1'b0;

        case (state)
            S_HALTED: begin
                if (Run) state_nxt = S_FETCH1;
            end
            S_FETCH1: begin
                ctl.gate_pc = 1'b1;
                ctl.ld_mar  = 1'b1;
                ctl.ld_pc   = 1'b1;
                ctl.pcmux   = PCMUX_INC;
                ctr_load    = 1'b1;
                state_nxt   = S_FETCH2;
            end
            S_FETCH2: begin
                ctl.mem_oe = 1'b0;
                ctl.ld_mdr = ctr_zero;
                ctr_dec    = 1'b1;
                if (ctr_zero) state_nxt = S_FETCH3;
            end
            S_FETCH3: begin
                ctl.gate_mdr = 1'b1;
                ctl.ld_ir    = 1'b1;
                state_nxt    = PAUSE_EN ? S_PAUSE_IR1 : S_DECODE;
            end
            S_PAUSE_IR1: begin
                if (Continue) state_nxt = S_PAUSE_IR2;
            end
            S_PAUSE_IR2: begin
                if (!Continue) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ctl.ld_ben = 1'b1;
                case (Opcode)
                    OP_ADD:   state_nxt = S_ADD;
                    OP_AND:   state_nxt = S_AND;
                    OP_NOT:   state_nxt = S_NOT;
                    OP_BR:    state_nxt = S_BR;
                    OP_JMP:   state_nxt = S_JMP;
                    OP_JSR:   state_nxt = S_JSR;
                    OP_LDR:   state_nxt = S_LDR1;
                    OP_STR:   state_nxt = S_STR1;
                    OP_PAUSE: state_nxt = S_PAUSE1;
                    default:  state_nxt = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                ctl.sr1mux   = 1'b1;
                ctl.sr2mux   = IR_5;
                ctl.aluk     = (state == S_ADD) ? ALUK_ADD :
                               (state == S_AND) ? ALUK_AND : ALUK_NOT;
                ctl.gate_alu = 1'b1;
                ctl.ld_reg   = 1'b1;
                ctl.ld_cc    = 1'b1;
                state_nxt    = S_FETCH1;
            end
            S_BR: begin
                state_nxt = BEN ? S_BR_TAKE : S_FETCH1;
            end
            S_BR_TAKE: begin
                ctl.addr1mux = 1'b0;
                ctl.addr2mux = ADDR2_OFF9;
                ctl.pcmux    = PCMUX_ADDR;
                ctl.ld_pc    = 1'b1;
                state_nxt    = S_FETCH1;
            end
            // JSRR reuses the JMP datapath setting: PC <= SR1 + 0.
            S_JMP, S_JSRR: begin
                ctl.sr1mux   = 1'b1;
                ctl.addr1mux = 1'b1;
                ctl.addr2mux = ADDR2_ZERO;
                ctl.pcmux    = PCMUX_ADDR;
                ctl.ld_pc    = 1'b1;
                state_nxt    = S_FETCH1;
            end
            S_JSR: begin
                ctl.gate_pc = 1'b1;
                ctl.drmux   = 1'b1;
                ctl.ld_reg  = 1'b1;
                state_nxt   = IR_11 ? S_JSR_OFF : S_JSRR;
            end
            S_JSR_OFF: begin
                ctl.addr1mux = 1'b0;
                ctl.addr2mux = ADDR2_OFF11;
                ctl.pcmux    = PCMUX_ADDR;
                ctl.ld_pc    = 1'b1;
                state_nxt    = S_FETCH1;
            end
            S_LDR1, S_STR1: begin
                ctl.sr1mux      = 1'b1;
                ctl.addr1mux    = 1'b1;
                ctl.addr2mux    = ADDR2_OFF6;
                ctl.gate_marmux = 1'b1;
                ctl.ld_mar      = 1'b1;
                ctr_load        = (state == S_LDR1);
                state_nxt       = (state == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR2: begin
                ctl.mem_oe = 1'b0;
                ctl.ld_mdr = ctr_zero;
                ctr_dec    = 1'b1;
                if (ctr_zero) state_nxt = S_LDR3;
            end
            S_LDR3: begin
                ctl.gate_mdr = 1'b1;
                ctl.ld_reg   = 1'b1;
                ctl.ld_cc    = 1'b1;
                ctl.drmux    = 1'b0;
                state_nxt    = S_FETCH1;
            end
            S_STR2: begin
                ctl.sr1mux   = 1'b0;
                ctl.aluk     = ALUK_PASS;
                ctl.gate_alu = 1'b1;
                ctl.ld_mdr   = 1'b1;
                ctr_load     = 1'b1;
                state_nxt    = S_STR3;
            end
            S_STR3: begin
                ctl.mem_we = 1'b0;
                ctr_dec    = 1'b1;
                if (ctr_zero) state_nxt = S_FETCH1;
            end
            // Two-step handshake so a held Continue advances only one step.
            S_PAUSE1: begin
                ctl.ld_led = 1'b1;
                if (Continue) state_nxt = S_PAUSE2;
            end
            S_PAUSE2: begin
                if (!Continue) state_nxt = S_FETCH1;
            end
            default: begin
                state_nxt = S_HALTED;
            end
        endcase
    end

    assign LD_MAR     = ctl.ld_mar;
    assign LD_MDR     = ctl.ld_mdr;
    assign LD_IR      = ctl.ld_ir;
    assign LD_BEN     = ctl.ld_ben;
    assign LD_CC      = ctl.ld_cc;
    assign LD_REG     = ctl.ld_reg;
    assign LD_PC      = ctl.ld_pc;
    assign LD_LED     = ctl.ld_led;
    assign GatePC     = ctl.gate_pc;
    assign GateMDR    = ctl.gate_mdr;
    assign GateALU    = ctl.gate_alu;
    assign GateMARMUX = ctl.gate_marmux;
    assign PCMUX      = ctl.pcmux;
    assign DRMUX      = ctl.drmux;
    assign SR1MUX     = ctl.sr1mux;
    assign SR2MUX     = ctl.sr2mux;
    assign ADDR1MUX   = ctl.addr1mux;
    assign ADDR2MUX   = ctl.addr2mux;
    assign ALUK       = ctl.aluk;
    assign Mem_CE     = 1'b0;
    assign Mem_UB     = 1'b0;
    assign Mem_LB     = 1'b0;
    assign Mem_OE     = ctl.mem_oe;
    assign Mem_WE     = ctl.mem_we;

endmodule
